univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register.
- Supports hold, shift-left, shift-right and parallel load, with serial in/out at both ends.
- Adds an autonomous burst-shift engine: one start pulse shifts the register a programmed number of positions, then reports completion.
- Used as a serialiser/deserialiser and data-alignment stage between parallel datapaths and bit-serial links.

Parameters:
- WIDTH, 4: register width in bits; legal range 2 or more.
- CNT_W, $clog2(WIDTH+1): width of the burst length and internal counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load; IDLE only
- d  in  WIDTH  parallel load data
- sin_msb  in  1  bit entering q[WIDTH-1] on a right shift
- sin_lsb  in  1  bit entering q[0] on a left shift
- start  in  1  burst request, single-cycle pulse
- len  in  CNT_W  burst shift count
- dir  in  1  burst direction: 0 right, 1 left
- q  out  WIDTH  register contents
- sout_msb  out  1  equals q[WIDTH-1]
- sout_lsb  out  1  equals q[0]
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst_n=0):
  - q=0, busy=0, done=0, state IDLE, counter=0.
  - Takes effect immediately, including mid-burst; the burst is abandoned and no done pulse is produced.
- State IDLE, start=0: on each rising edge, mode applies:
  - 00: q holds.
  - 01: q <= {sin_msb, q[WIDTH-1:1]}.
  - 10: q <= {q[WIDTH-2:0], sin_lsb}.
  - 11: q <= d.
  - Latency: 1 clock.
- State IDLE, start=1:
  - start has priority over mode; mode is ignored that edge and q holds.
  - Effective length L = min(len, WIDTH).
  - If L>0: counter <= L, dir is latched, state goes to BURST, busy=1 from the next cycle.
  - If L=0: stay in IDLE, q unchanged, done=1 for exactly the next cycle.
- State BURST:
  - Each edge performs one shift in the latched direction and decrements the counter.
  - Serial inputs are used as in mode shifts (see the ROTATE_EN exception below).
  - mode, start, dir and len are ignored while busy.
  - On the edge performing the final shift (counter 1->0): state goes to IDLE, busy<=0, done<=1 for one cycle.
  - A burst of L started at edge E0 shifts at edges E1..EL; done is high during the cycle after EL.
- done is never high while busy is high.
- A start arriving in the same cycle done is high is accepted normally, since the block is already IDLE.
- sout_msb and sout_lsb are combinational from q; no added latency.

Optional Feature:
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined: burst shifts rotate. A right burst feeds q[0] into the MSB; a left burst feeds q[WIDTH-1] into the LSB. sin_msb and sin_lsb are ignored during BURST. Mode shifts are unchanged.
- Undefined: burst shifts take sin_msb or sin_lsb exactly as mode shifts do.

Decomposition:
- Shared package univ_shift_pkg holds:
  - mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - state encodings ST_IDLE, ST_BURST;
  - direction constants DIR_R, DIR_L.
- One natural sub-module, shift_burst_ctrl: the counter/FSM producing busy, done and the per-cycle shift enable/direction. The data register stays in the top level.

Test Plan (WIDTH=4):
- Reset mid-burst: load 1010, start len=3 dir=0; assert rst_n=0 after the 1st shift -> q=0000, busy=0 immediately, no done pulse after release.
- Mode ops: load d=1001, then mode=01 with sin_msb=1 -> 1100; then mode=10 with sin_lsb=0 -> 1000; then mode=00 for 3 clocks -> 1000 holds.
- Burst right, non-rotate: load 1101, sin_msb=0, start len=2 dir=0 -> busy for 2 cycles, q=0110 then 0011, done for 1 cycle after the 2nd shift.
- Burst left, rotate (UNIV_SHIFT_ROTATE_EN defined): load 1001, start len=1 dir=1 -> q=0011, done 1 cycle. Same stimulus without the macro and sin_lsb=0 -> q=0010.
- Boundaries:
  - len=0 -> q unchanged, busy stays 0, done pulses once.
  - len=7 -> clamped to 4 shifts, exactly 4 busy cycles.
- Ignored inputs during burst: mode=11 with d=1111 and a second start while busy -> q is unaffected by the load and the second start; back-to-back start in the done cycle -> a new burst begins.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register and its burst controller.
package univ_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/univ_shift_reg_burst_ctrl.sv
// Burst engine: counts shifts, latches direction, and produces busy/done.
// Handshake: start is a one-cycle request taken whenever busy=0; done pulses for one cycle at completion.
module shift_burst_ctrl
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    output state_e           state,
    output logic             shift_dir,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_len;

    // Requests longer than the register are clamped to one full pass.
    assign eff_len = (len > MAX_LEN) ? MAX_LEN : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift_dir <= DIR_R;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (eff_len != '0) begin
                            cnt       <= eff_len;
                            shift_dir <= dir;
                            state     <= ST_BURST;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/load modes and an autonomous burst-shift engine.
// Define UNIV_SHIFT_ROTATE_EN to make burst shifts rotate instead of taking the serial inputs.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    state_e state;
    logic   shift_dir;
    logic   burst_msb;
    logic   burst_lsb;

    shift_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .dir       (dir),
        .state     (state),
        .shift_dir (shift_dir),
        .busy      (busy),
        .done      (done)
    );

`ifdef UNIV_SHIFT_ROTATE_EN
    assign burst_msb = q[0];
    assign burst_lsb = q[WIDTH-1];
`else
    assign burst_msb = sin_msb;
    assign burst_lsb = sin_lsb;
`endif

    // In IDLE a start request wins over mode, so q holds on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (state == ST_BURST) begin
            if (shift_dir == DIR_L) q <= {q[WIDTH-2:0], burst_lsb};
            else                    q <= {burst_msb, q[WIDTH-1:1]};
        end else if (!start) begin
            case (mode)
                MODE_HOLD: q <= q;
                MODE_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: table-driven mode ops plus burst sequences.
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_msb;
    logic             sin_lsb;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]       mode;
        logic [WIDTH-1:0] d;
        logic             sin_msb;
        logic             sin_lsb;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .d        (d),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .start    (start),
        .len      (len),
        .dir      (dir),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        mode = 2'b11;
        d    = val;
        tick();
        mode = 2'b00;
        check("load", q, val);
    endtask

    initial begin
        int busy_cycles;
        bit seen_done;

        vecs[0] = '{2'b11, 4'b1001, 1'b0, 1'b0, 4'b1001};
        vecs[1] = '{2'b01, 4'b0000, 1'b1, 1'b0, 4'b1100};
        vecs[2] = '{2'b10, 4'b0000, 1'b0, 1'b0, 4'b1000};
        vecs[3] = '{2'b00, 4'b1111, 1'b1, 1'b1, 4'b1000};
        vecs[4] = '{2'b00, 4'b0101, 1'b0, 1'b1, 4'b1000};
        vecs[5] = '{2'b00, 4'b0011, 1'b1, 1'b0, 4'b1000};
        vecs[6] = '{2'b10, 4'b0000, 1'b0, 1'b1, 4'b0001};
        vecs[7] = '{2'b01, 4'b0000, 1'b1, 1'b0, 4'b1000};

        rst_n = 1'b0; mode = 2'b00; d = '0; sin_msb = 1'b0; sin_lsb = 1'b0;
        start = 1'b0; len = '0; dir = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_q", q, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // mode operations from the table
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode; d = vecs[i].d;
            sin_msb = vecs[i].sin_msb; sin_lsb = vecs[i].sin_lsb;
            tick();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_sout_msb", i), sout_msb, vecs[i].exp_q[WIDTH-1]);
            check($sformatf("vec%0d_sout_lsb", i), sout_lsb, vecs[i].exp_q[0]);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end
        mode = 2'b00;

        // burst right len=2
        load(4'b1101);
        sin_msb = 1'b0; start = 1'b1; len = 3'd2; dir = 1'b0; mode = 2'b11; d = 4'b0000;
        tick();
        start = 1'b0; mode = 2'b00;
        check("br_e0_q", q, 4'b1101);
        check("br_e0_busy", busy, 1);
        tick();
`ifdef UNIV_SHIFT_ROTATE_EN
        check("br_e1_q", q, 4'b1110);
`else
        check("br_e1_q", q, 4'b0110);
`endif
        check("br_e1_busy", busy, 1);
        check("br_e1_done", done, 0);
        tick();
`ifdef UNIV_SHIFT_ROTATE_EN
        check("br_e2_q", q, 4'b0111);
`else
        check("br_e2_q", q, 4'b0011);
`endif
        check("br_e2_busy", busy, 0);
        check("br_e2_done", done, 1);
        tick();
        check("br_after_done", done, 0);

        // burst left len=1
        load(4'b1001);
        sin_lsb = 1'b0; start = 1'b1; len = 3'd1; dir = 1'b1;
        tick();
        start = 1'b0;
        check("bl_e0_busy", busy, 1);
        tick();
`ifdef UNIV_SHIFT_ROTATE_EN
        check("bl_e1_q", q, 4'b0011);
`else
        check("bl_e1_q", q, 4'b0010);
`endif
        check("bl_e1_done", done, 1);
        check("bl_e1_busy", busy, 0);
        tick();
        check("bl_after_done", done, 0);

        // len=0: immediate done, no shift
        load(4'b0110);
        start = 1'b1; len = 3'd0; dir = 1'b0;
        tick();
        start = 1'b0;
        check("len0_q", q, 4'b0110);
        check("len0_busy", busy, 0);
        check("len0_done", done, 1);
        tick();
        check("len0_done_once", done, 0);
        check("len0_q_hold", q, 4'b0110);

        // len=7 clamps to 4 shifts
        load(4'b1011);
        sin_msb = 1'b1; start = 1'b1; len = 3'd7; dir = 1'b0;
        busy_cycles = 0; seen_done = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            if (busy) busy_cycles++;
            if (done) seen_done = 1'b1;
            else tick();
        end
        check("len7_done_seen", seen_done, 1);
        check("len7_busy_cycles", busy_cycles, 4);
`ifdef UNIV_SHIFT_ROTATE_EN
        check("len7_q", q, 4'b1011);
`else
        check("len7_q", q, 4'b1111);
`endif
        tick();

        // ignored inputs while busy, then back-to-back start in the done cycle
        load(4'b0001);
        sin_msb = 1'b0; sin_lsb = 1'b0; start = 1'b1; len = 3'd2; dir = 1'b1;
        tick();
        mode = 2'b11; d = 4'b1111; start = 1'b1; len = 3'd1; dir = 1'b0;
        tick();
        check("ign_e1_q", q, 4'b0010);
        mode = 2'b00; start = 1'b0;
        tick();
        check("ign_e2_q", q, 4'b0100);
        check("ign_e2_done", done, 1);
        start = 1'b1; len = 3'd1; dir = 1'b0;
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        check("b2b_q_hold", q, 4'b0100);
        tick();
        check("b2b_q", q, 4'b0010);
        check("b2b_done", done, 1);
        tick();

        // reset mid-burst
        load(4'b1010);
        sin_msb = 1'b0; start = 1'b1; len = 3'd3; dir = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("rst_mid_e1_q", q, 4'b0101);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_q", q, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        check("rst_mid_no_done", seen_done, 0);
        check("rst_mid_q_after", q, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
